mul_add_16bit: RTL and testbench

//   Sequential radix-2 shift-add multiply-accumulate: product = A*B + C, unsigned.

---
 rtl/mul_add_16bit.sv | 118 +++++++++++
 tb/tb_mul_add_16bit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_16bit.sv
// Sequential shift-add multiply-accumulate: product = A*B + C (unsigned).
// Consumes one multiplier bit per clock; shares the divider's start/done handshake.
module mul_add_16bit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CW-1:0]    count_r;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; the unused encoding behaves as IDLE
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) next_state_s = S_CALC;
                else       next_state_s = S_IDLE;
            end
            S_CALC: begin
                if (count_r == CNT_ZERO) next_state_s = S_FINISH;
                else                     next_state_s = S_CALC;
            end
            S_FINISH: next_state_s = S_IDLE;
            default: begin
                if (start) next_state_s = S_CALC;
                else       next_state_s = S_IDLE;
            end
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) load_s = 1'b1;
                else       load_s = 1'b0;
            end
            S_CALC:   step_s   = 1'b1;
            S_FINISH: finish_s = 1'b1;
            default: begin
                if (start) load_s = 1'b1;
                else       load_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs; acc is 2*WIDTH wide so A*B+C cannot overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= CNT_ZERO;
            product  <= {PW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (load_s) begin
            acc_r    <= {{WIDTH{1'b0}}, C};
            mcand_r  <= {{WIDTH{1'b0}}, A};
            mplier_r <= B;
            count_r  <= CNT_LAST;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (step_s) begin
            if (mplier_r[0]) acc_r <= acc_r + mcand_r;
            else             acc_r <= acc_r;
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            count_r  <= count_r - CNT_ONE;
        end else if (finish_s) begin
            product <= acc_r;
            done    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: tb/tb_mul_add_16bit.sv
// Self-checking bench for mul_add_16bit: random and directed operands checked
// against plain integer arithmetic A*B+C, plus handshake, latency and reset checks.
module tb_mul_add_16bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    mul_add_16bit #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .C       (C),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mac(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        longint unsigned r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r[31:0];
    endfunction

    // Launch one operation and wait (bounded) for done; reports product, latency, busy shape.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          output logic [31:0] p, output int lat, output bit busy_ok);
        @(negedge clk);
        A = a; B = b; C = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && lat < 40);
        p = product;
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; A = 16'd0; B = 16'd0; C = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (product !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: product=%0h busy=%0b done=%0b, want 0/0/0", product, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] p; int lat; bit bok;
        run_op(16'd7, 16'd9, 16'd5, p, lat, bok);
        checks++;
        if (p !== 32'h0000_0044) begin
            failures++; $display("FAIL basic_product: got %0h want 44", p);
        end
        checks++;
        if (lat !== 17) begin
            failures++; $display("FAIL basic_latency: got %0d want 17", lat);
        end
        checks++;
        if (bok !== 1'b1) begin
            failures++; $display("FAIL basic_busy: busy/done shape wrong, got %0b want 1", bok);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || product !== 32'h0000_0044 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold: done=%0b busy=%0b product=%0h, want 1/0/44", done, busy, product);
        end
    endtask

    task automatic test_max();
        logic [31:0] p; int lat; bit bok;
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, p, lat, bok);
        checks++;
        if (p !== 32'hFFFF_0000) begin
            failures++; $display("FAIL max_product: got %0h want ffff0000", p);
        end
    endtask

    task automatic test_divider_roundtrip();
        logic [31:0] p; int lat; bit bok;
        logic [15:0] dividend, divisor, q, r;
        run_op(16'd142, 16'd7, 16'd6, p, lat, bok);
        checks++;
        if (p !== 32'd1000) begin
            failures++; $display("FAIL div_1000: got %0d want 1000", p);
        end
        for (int i = 0; i < 20; i++) begin
            dividend = 16'($urandom_range(0, 65535));
            divisor  = 16'($urandom_range(1, 65535));
            q = dividend / divisor;
            r = dividend % divisor;
            run_op(q, divisor, r, p, lat, bok);
            checks++;
            if (p !== {16'd0, dividend} || lat !== 17) begin
                failures++;
                $display("FAIL div_roundtrip: q=%0d d=%0d r=%0d got %0d lat %0d want %0d lat 17",
                         q, divisor, r, p, lat, dividend);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] p; int lat; bit bok;
        logic [15:0] a, b, c;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            run_op(a, b, c, p, lat, bok);
            checks++;
            if (p !== ref_mac(a, b, c) || lat !== 17 || bok !== 1'b1) begin
                failures++;
                $display("FAIL random_mac: a=%0h b=%0h c=%0h got %0h lat %0d busy %0b want %0h lat 17",
                         a, b, c, p, lat, bok, ref_mac(a, b, c));
            end
        end
    endtask

    task automatic test_zero_operands();
        logic [31:0] p; int lat; bit bok;
        run_op(16'd0, 16'h1234, 16'hABCD, p, lat, bok);
        checks++;
        if (p !== 32'h0000_ABCD || lat !== 17) begin
            failures++; $display("FAIL zero_a: got %0h lat %0d want abcd lat 17", p, lat);
        end
        run_op(16'h1234, 16'd0, 16'd0, p, lat, bok);
        checks++;
        if (p !== 32'd0 || lat !== 17) begin
            failures++; $display("FAIL zero_b: got %0h lat %0d want 0 lat 17", p, lat);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        @(negedge clk);
        A = 16'd3; B = 16'd5; C = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        A = 16'd100; B = 16'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 16'd999;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL ignore_busy: busy=%0b done=%0b want 1/0", busy, done);
        end
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
        checks++;
        if (product !== 32'd15) begin
            failures++; $display("FAIL ignore_product: got %0d want 15", product);
        end
        A = 16'd2; B = 16'd4; C = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || product !== 32'd15) begin
            failures++;
            $display("FAIL b2b_accept: done=%0b busy=%0b product=%0d want 0/1/15", done, busy, product);
        end
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
        checks++;
        if (product !== ref_mac(16'd2, 16'd4, 16'd1) || guard !== 17) begin
            failures++; $display("FAIL b2b_result: got %0d lat %0d want 9 lat 17", product, guard);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p; int lat; bit bok;
        logic [15:0] a, b, c;
        int seen_done;
        @(negedge clk);
        A = 16'd50; B = 16'd60; C = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            failures++;
            $display("FAIL midreset_clear: busy=%0b done=%0b product=%0h want 0/0/0", busy, done, product);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        repeat (20) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) seen_done++; end
        checks++;
        if (seen_done !== 0) begin
            failures++; $display("FAIL midreset_idle: activity cycles %0d want 0", seen_done);
        end
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
        run_op(a, b, c, p, lat, bok);
        checks++;
        if (p !== ref_mac(a, b, c) || lat !== 17) begin
            failures++;
            $display("FAIL midreset_after: got %0h lat %0d want %0h lat 17", p, lat, ref_mac(a, b, c));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max();
        test_divider_roundtrip();
        test_random();
        test_zero_operands();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
